piso_4_bit_tx: RTL
==================

# piso_4_bit_tx

Parallel-in serial-out transmitter that drives the serial line consumed by the 4-bit SISO/SIPO shift registers. It accepts a parallel word through a ready/load handshake and shifts it out one bit per clock on `sout`. A `frame` qualifier marks the bits and a `last` flag marks the final one. Back-to-back words stream with no idle gap. The block sits at the transmit end of the team's serial link, directly in front of a shift-register receiver.

## Interface
Parameters:
- `WIDTH`, 4: bits per word; legal range 2..16.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` is sent first; 0 = bit 0 is sent first.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  parallel word; sampled only on an accepted load.
- `load`  in  1  load request; accepted when `load && ready` at a rising edge.
- `ready`  out  1  the transmitter can accept a word this cycle.
- `sout`  out  1  serial data, registered.
- `frame`  out  1  high while `sout` carries a valid data bit, registered.
- `last`  out  1  high during the final bit of a word, registered.
- `q`  out  WIDTH  current shift-register contents, for debug and visibility.

## Operation
- FSM has two states:
  - IDLE: `frame`=0, `sout`=0.
  - SHIFT: one bit is driven per cycle.
- Bit counter `cnt` is `$clog2(WIDTH)` bits wide and counts 0..WIDTH-1 within a word.
- `ready` = `!reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`. It is combinational from state only and never depends on `load`.
- On an accepted load:
  - `din` enters the shift register.
  - `cnt` is set to 0.
  - State goes to SHIFT.
- In SHIFT, every cycle:
  - `sout` = shift-register MSB if `MSB_FIRST`, else LSB.
  - The register shifts toward the output end and fills with 0.
  - `cnt` increments.
- `last`=1 exactly when `cnt==WIDTH-1` in SHIFT.
- At `cnt==WIDTH-1`:
  - With an accepted load: reload and stay in SHIFT, so the frame is contiguous.
  - Otherwise: go to IDLE.
- `load` while `ready`=0 is ignored. The word is not latched and no error is flagged; the sender must hold `load` until `ready`.
- `q` shows the register after the most recent edge. It reads 0 in IDLE after a completed word.
- Reset mid-word aborts the word; remaining bits are never sent.

## Timing
- Reset values, on the edge where `reset`=1:
  - `sout`=0, `frame`=0, `last`=0, `q`=0.
  - State = IDLE, `cnt`=0.
  - `ready`=0 while `reset` is high and 1 on the first cycle after it drops.
- Latency: load accepted at edge N → first bit on `sout` with `frame`=1 after edge N, valid for the cycle N..N+1.
- A word occupies exactly WIDTH consecutive `frame` cycles. `last` is high in the WIDTH-th cycle.
- Back-to-back: a load accepted on the `last` cycle gives the next word's first bit in the following cycle, with no gap.
- Receiver contract: sample `sout` on the rising edge when `frame`=1. After WIDTH sampled edges, a 4-bit SISO/SIPO holds the word in `q`.
- Simultaneous `reset` and `load`: reset wins and the word is dropped.

## Structure
- Shared package `serial_pkg` holds:
  - state encoding localparams `ST_IDLE`=0 and `ST_SHIFT`=1;
  - default width constant `SER_WIDTH`=4;
  - bit-order constants `MSB_FIRST_C` and `LSB_FIRST_C`.
  
  The matching receiver imports the same package.
- One natural sub-module, `shift_reg_pl`: a WIDTH-bit parallel-load shift register with a direction parameter, synchronous reset, and `ld`/`sh` enables. The FSM, counter and handshake stay in the top module.

## Test plan
All scenarios use WIDTH=4 unless stated.
- Single word, MSB_FIRST=1: after reset, load 4'b1011 for one cycle.
  - → `sout`=1,0,1,1 on the next 4 cycles, with `frame`=1 for all 4.
  - → `last`=1 only on the 4th cycle; `ready`=0 for cycles 1–3 and 1 on cycle 4.
  - → back in IDLE, `sout`=0 and `frame`=0.
- Back-to-back: load 4'b1011, then hold `load` with 4'b0110 until it is accepted on the `last` cycle.
  - → `frame` stays high for 8 contiguous cycles.
  - → `sout`=1,0,1,1,0,1,1,0.
  - → `last` pulses on cycles 4 and 8.
- Ignored load: load 4'b1111; on cycle 2 drive `load`=1 with 4'b0000 for one cycle only.
  - → `sout`=1,1,1,1.
  - → no second frame follows.
- Reset mid-word: load 4'b1001 and assert `reset` after 2 bits.
  - → next cycle `frame`=0, `sout`=0, `q`=0.
  - → `ready`=1 one cycle after `reset` deasserts; the remaining 2 bits are never sent.
- LSB_FIRST (MSB_FIRST=0): load 4'b1101.
  - → `sout`=1,0,1,1.
- Loopback over 16 random words: `sout` feeds a 4-bit SISO whose shift is enabled by `frame`.
  - → after each `last` edge, the receiver's `q` equals the transmitted word.
  - → zero mismatches.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: the transmitter and the matching
// shift-register receiver both import this package so that state encoding,
// default word width and bit-order constants stay in one place.
package serial_pkg;

    // FSM state encoding shared by transmit and receive sides
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Default number of bits per serial word
    localparam int SER_WIDTH = 4;

    // Bit-order selectors: MSB_FIRST_C sends bit WIDTH-1 first
    localparam bit MSB_FIRST_C = 1'b1;
    localparam bit LSB_FIRST_C = 1'b0;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } tx_state_e;

    // Width of a counter that must reach width-1, never narrower than one bit
    function automatic int cntWidth(input int width);
        return (width < 3) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_reg_pl.sv
// WIDTH-bit parallel-load shift register. A load takes priority over a
// shift; shifting moves data toward the output end selected by MSB_FIRST
// and back-fills with zeros, so the register drains to 0 after WIDTH shifts.
module shift_reg_pl
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next register value: parallel load, shift toward the output end, or hold
    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end else if (sh) begin
            if (MSB_FIRST) begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
            end else begin
                data_d = {1'b0, data_q[WIDTH-1:1]};
            end
        end
    end

    // Storage with synchronous clear so an aborted word leaves nothing behind
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/piso_4_bit_tx.sv
// Parallel-in serial-out transmitter. A word accepted through the
// load/ready handshake is presented one bit per clock on sout, with frame
// marking valid bits and last marking the final bit. A load accepted on the
// last bit reloads immediately so consecutive words stream without a gap.
module piso_4_bit_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = MSB_FIRST_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             frame,
    output logic             last,
    output logic [WIDTH-1:0] q
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sout_q;
    logic          sout_d;
    logic          frame_q;
    logic          frame_d;
    logic          last_q;
    logic          last_d;

    logic          loadAccept;
    logic          loadEn;
    logic          shiftEn;
    logic          nextBit;

    // The sender may hand over a word when idle or while the final bit is out
    assign ready = !reset && ((state_q == IDLE) ||
                              ((state_q == SHIFT) && (cnt_q == CNT_LAST)));
    assign loadAccept = load && ready;

    shift_reg_pl #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) uShiftReg (
        .clock(clock),
        .reset(reset),
        .ld   (loadEn),
        .sh   (shiftEn),
        .d    (din),
        .q    (q)
    );

    // Next state, counter and register enables; the output flops are fed the
    // bit that sits at the output end of the shift register after this edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loadEn  = 1'b0;
        shiftEn = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (loadAccept) begin
                    loadEn  = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (loadAccept) begin
                    loadEn  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    shiftEn = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shiftEn = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (loadEn) begin
            nextBit = MSB_FIRST ? din[WIDTH-1] : din[0];
        end else begin
            nextBit = MSB_FIRST ? q[WIDTH-2] : q[1];
        end

        frame_d = (state_d == SHIFT);
        sout_d  = frame_d && nextBit;
        last_d  = frame_d && (cnt_d == CNT_LAST);
    end

    // State, bit counter and registered serial outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            frame_q <= frame_d;
            last_q  <= last_d;
        end
    end

    assign sout  = sout_q;
    assign frame = frame_q;
    assign last  = last_q;

endmodule
